// File: rtl/lts_pkg.sv
// lts_pkg: LTS sign masks, generator state type and bin-value helper shared by TX generator and RX equalizer
package lts_pkg;
  localparam int FFT_LEN = 64;
  // Bit 63 is bin k=0. Non-zero bins are k=1..26 and k=38..63, as in the 802.11 L-sequence.
  localparam logic [63:0] POS_MASK = 64'h4D41_95E0_0335_F9AF;
  localparam logic [63:0] NEG_MASK = 64'h32BE_6A00_00CA_0650;
  typedef enum logic {IDLE, SEND} lts_gen_state_t;
  // +A, -A or 0 for bin k; -A saturates so -(-32768) becomes +32767
  function automatic logic signed [15:0] lts_bin(input logic [5:0] k, input logic signed [15:0] a);
    logic [5:0] idx;
    idx = 6'd63 - k;
    return POS_MASK[idx] ? a : NEG_MASK[idx] ? ((a == 16'sh8000) ? 16'sh7FFF : -a) : 16'sh0000;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI-Stream register slice with registered tready toward the source
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             m_tready
);
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  assign s_tready = ~r_s_valid;
  assign m_tvalid = r_m_valid;
  assign m_tdata  = r_m_data;
  // Refill the output stage from the skid entry first; park an accepted beat in the skid entry while stalled
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else if (!r_m_valid || m_tready) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_s_data;
        r_s_valid <= 1'b0;
      end else begin
        r_m_valid <= s_tvalid;
        r_m_data  <= s_tdata;
      end
    end else if (s_tvalid && !r_s_valid) begin
      r_s_valid <= 1'b1;
      r_s_data  <= s_tdata;
    end
  end
endmodule

// File: rtl/lts_symbol_generator.sv
// lts_symbol_generator: streams N_SYMBOLS frequency-domain LTS symbols over AXI-Stream; LTS_OUT_REG_EN adds an output skid buffer
module lts_symbol_generator #(
  parameter int FFT_LEN   = lts_pkg::FFT_LEN,
  parameter int N_SYMBOLS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [15:0] amplitude_in,
  output logic        lts_axis_tvalid,
  output logic        lts_axis_tlast,
  output logic [15:0] lts_re_axis_tdata,
  output logic [15:0] lts_im_axis_tdata,
  input  logic        lts_axis_tready,
  output logic        busy_out,
  output logic        done_out
);
  import lts_pkg::*;
  localparam int KW = $clog2(FFT_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(FFT_LEN - 1);
  localparam logic [3:0] S_LAST = 4'(N_SYMBOLS - 1);
  lts_gen_state_t     r_state;
  logic [KW-1:0]      r_k;
  logic [3:0]         r_sym;
  logic signed [15:0] r_amp;
  logic signed [15:0] r_re;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;
  logic               r_done;
  logic               w_ready;
  logic               w_start;
  logic               w_hs;
  logic               w_k_last;
  logic               w_final;
  logic [KW-1:0]      w_k_nxt;
  assign w_hs     = r_valid & w_ready;
  assign w_k_last = r_k == K_LAST;
  assign w_final  = w_hs & w_k_last & (r_sym == S_LAST);
  assign w_k_nxt  = w_k_last ? '0 : r_k + KW'(1);
  // Core FSM: beat k is precomputed into the output registers so a start shows k=0 one cycle later
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_sym   <= '0;
      r_amp   <= '0;
      r_re    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_state <= SEND;
          r_busy  <= 1'b1;
          r_valid <= 1'b1;
          r_k     <= '0;
          r_sym   <= '0;
          r_amp   <= amplitude_in;
          r_re    <= lts_bin(6'd0, amplitude_in);
          r_last  <= 1'b0;
        end
      end else if (w_final) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_re    <= '0;
        r_k     <= '0;
        r_sym   <= '0;
        r_done  <= 1'b1;
      end else if (w_hs) begin
        r_k    <= w_k_nxt;
        r_sym  <= w_k_last ? r_sym + 4'd1 : r_sym;
        r_re   <= lts_bin(w_k_nxt, r_amp);
        r_last <= w_k_nxt == K_LAST;
      end
    end
  end
`ifdef LTS_OUT_REG_EN
  logic        w_s_ready;
  logic        w_m_valid;
  logic [32:0] w_m_data;
  logic        w_tail;
  logic        w_out_fin;
  logic        r_tail;
  logic        r_odone;
  axis_skid_buffer #(.WIDTH(33)) u_skid (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .s_tvalid (r_valid),
    .s_tready (w_s_ready),
    .s_tdata  ({r_last, r_re, 16'h0000}),
    .m_tvalid (w_m_valid),
    .m_tdata  (w_m_data),
    .m_tready (lts_axis_tready)
  );
  assign w_ready   = w_s_ready;
  assign w_tail    = r_done | r_tail;
  assign w_out_fin = w_tail & w_m_valid & lts_axis_tready & w_s_ready;
  assign w_start   = start_in & ~w_tail;
  assign busy_out  = r_busy | w_tail;
  assign done_out  = r_odone;
  assign lts_axis_tvalid = w_m_valid;
  assign {lts_axis_tlast, lts_re_axis_tdata, lts_im_axis_tdata} = w_m_data;
  // Hold busy while the final beats drain from the skid buffer; done follows the last output handshake
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tail  <= 1'b0;
      r_odone <= 1'b0;
    end else begin
      r_tail  <= w_tail & ~w_out_fin;
      r_odone <= w_out_fin;
    end
  end
`else
  assign w_ready           = lts_axis_tready;
  assign w_start           = start_in;
  assign busy_out          = r_busy;
  assign done_out          = r_done;
  assign lts_axis_tvalid   = r_valid;
  assign lts_axis_tlast    = r_last;
  assign lts_re_axis_tdata = r_re;
  assign lts_im_axis_tdata = '0;
`endif
endmodule
